// File: rtl/vin_timing_meas.sv
// Video timing measurement for the FPD-Link input stream: measures line/frame
// geometry, qualifies it over consecutive frames and reports lock.
module vin_timing_meas #(
   parameter int unsigned HW          = 12,
   parameter int unsigned VW          = 12,
   parameter int unsigned LOCK_FRAMES = 2,
   parameter int unsigned TIMEOUT_W   = 22
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          v_valid,
   input  logic          v_vsync,
   input  logic          v_hsync,
   input  logic          v_de,
   output logic [HW-1:0] h_total,
   output logic [HW-1:0] h_active,
   output logic [VW-1:0] v_total,
   output logic [VW-1:0] v_active,
   output logic          locked,
   output logic          frame_start,
   output logic          mode_change
);

   localparam int unsigned SW = 4;
   localparam logic [SW-1:0] LOCK_N = SW'(LOCK_FRAMES);

   typedef struct packed {
      logic                 vs_q;
      logic                 hs_q;
      logic                 de_q;
      logic [HW-1:0]        hcnt;
      logic [HW-1:0]        decnt;
      logic [HW-1:0]        line_total;
      logic [HW-1:0]        line_active;
      logic [HW-1:0]        ref_active;
      logic                 ref_vld;
      logic [VW-1:0]        v_tot_cnt;
      logic [VW-1:0]        v_act_cnt;
      logic                 frame_bad;
      logic                 armed;
      logic [HW-1:0]        prev_lt;
      logic [HW-1:0]        prev_la;
      logic [VW-1:0]        prev_vt;
      logic [VW-1:0]        prev_va;
      logic                 prev_vld;
      logic [SW-1:0]        stable_cnt;
      logic [TIMEOUT_W-1:0] wdcnt;
      logic [HW-1:0]        h_total;
      logic [HW-1:0]        h_active;
      logic [VW-1:0]        v_total;
      logic [VW-1:0]        v_active;
      logic                 locked;
      logic                 frame_start;
      logic                 mode_change;
   } state_t;

   state_t st;
   state_t st_nxt;

   logic          vs_rise, hs_rise, de_fall;
   logic          h_sat, de_sat, vt_sat, va_sat, de_run_bad, bad_c;
   logic [HW-1:0] cand_lt, cand_la;
   logic [VW-1:0] cand_vt, cand_va;
   logic          cand_same, cand_nonzero, match;
   logic [SW-1:0] stable_inc;

   // Edge detection and saturation / consistency events for this cycle
   always_comb begin
      vs_rise    = v_vsync & ~st.vs_q;
      hs_rise    = v_hsync & ~st.hs_q;
      de_fall    = ~v_de & st.de_q;
      h_sat      = ~hs_rise & (&st.hcnt);
      de_sat     = v_de & (&st.decnt);
      vt_sat     = hs_rise & (&st.v_tot_cnt);
      va_sat     = de_fall & (&st.v_act_cnt);
      de_run_bad = de_fall & st.ref_vld & (st.decnt != st.ref_active);
      bad_c      = st.frame_bad | de_run_bad | h_sat | de_sat | vt_sat | va_sat;
   end

   // Candidate for the ending frame; a DE fall in the vsync cycle still belongs to it
   always_comb begin
      cand_lt      = st.line_total;
      cand_vt      = st.v_tot_cnt;
      cand_la      = de_fall ? st.decnt : st.line_active;
      cand_va      = (de_fall && !va_sat) ? st.v_act_cnt + VW'(1) : st.v_act_cnt;
      cand_same    = !st.prev_vld ||
                     ((cand_lt == st.prev_lt) && (cand_la == st.prev_la) &&
                      (cand_vt == st.prev_vt) && (cand_va == st.prev_va));
      cand_nonzero = (cand_lt != '0) && (cand_la != '0) && (cand_vt != '0) && (cand_va != '0);
      match        = cand_same & cand_nonzero & ~bad_c;
      stable_inc   = (st.stable_cnt >= LOCK_N) ? LOCK_N : st.stable_cnt + SW'(1);
   end

   always_comb begin
      st_nxt             = st;
      st_nxt.frame_start = 1'b0;
      st_nxt.mode_change = 1'b0;
      st_nxt.vs_q        = v_vsync;
      st_nxt.hs_q        = v_hsync;
      st_nxt.de_q        = v_de;
      st_nxt.frame_bad   = bad_c;

      if (hs_rise) begin
         st_nxt.line_total = st.hcnt;
         st_nxt.hcnt       = HW'(1);
         if (!vt_sat) st_nxt.v_tot_cnt = st.v_tot_cnt + VW'(1);
      end else if (!h_sat) begin
         st_nxt.hcnt = st.hcnt + HW'(1);
      end

      if (v_de) begin
         if (!de_sat) st_nxt.decnt = st.decnt + HW'(1);
      end else if (de_fall) begin
         st_nxt.line_active = st.decnt;
         st_nxt.decnt       = '0;
         if (!va_sat) st_nxt.v_act_cnt = st.v_act_cnt + VW'(1);
         if (!st.ref_vld) begin
            st_nxt.ref_active = st.decnt;
            st_nxt.ref_vld    = 1'b1;
         end
      end

      if (!(&st.wdcnt)) st_nxt.wdcnt = st.wdcnt + TIMEOUT_W'(1);

      // Frame boundary: evaluate the ending frame, then restart frame counters
      if (vs_rise) begin
         st_nxt.frame_start = 1'b1;
         st_nxt.wdcnt       = '0;
         st_nxt.v_tot_cnt   = hs_rise ? VW'(1) : '0;
         st_nxt.v_act_cnt   = '0;
         st_nxt.frame_bad   = 1'b0;
         st_nxt.ref_vld     = 1'b0;
         if (!st.armed) begin
            st_nxt.armed = 1'b1;
         end else begin
            st_nxt.h_total  = cand_lt;
            st_nxt.h_active = cand_la;
            st_nxt.v_total  = cand_vt;
            st_nxt.v_active = cand_va;
            st_nxt.prev_lt  = cand_lt;
            st_nxt.prev_la  = cand_la;
            st_nxt.prev_vt  = cand_vt;
            st_nxt.prev_va  = cand_va;
            st_nxt.prev_vld = 1'b1;
            if (match) begin
               st_nxt.stable_cnt = stable_inc;
               st_nxt.locked     = (stable_inc == LOCK_N);
            end else begin
               st_nxt.stable_cnt  = '0;
               st_nxt.locked      = 1'b0;
               st_nxt.mode_change = st.locked;
            end
         end
      end else if (&st.wdcnt) begin
         st_nxt.locked      = 1'b0;
         st_nxt.stable_cnt  = '0;
         st_nxt.h_total     = '0;
         st_nxt.h_active    = '0;
         st_nxt.v_total     = '0;
         st_nxt.v_active    = '0;
         st_nxt.armed       = 1'b0;
         st_nxt.prev_vld    = 1'b0;
         st_nxt.mode_change = st.locked;
      end

      if (!v_valid) st_nxt = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= '0;
      else        st <= st_nxt;
   end

   assign h_total     = st.h_total;
   assign h_active    = st.h_active;
   assign v_total     = st.v_total;
   assign v_active    = st.v_active;
   assign locked      = st.locked;
   assign frame_start = st.frame_start;
   assign mode_change = st.mode_change;

endmodule

// File: doc/vin_timing_meas.md
# vin_timing_meas

Measures incoming video timing on the FPD-Link input stream and reports whether the mode is stable. It sits directly downstream of the FPD-Link receiver, on its pixel clock. It consumes the receiver's sync, data-enable and valid outputs, at two pixels per clock. Downstream blocks (frame buffer writer, mode check) use `locked`, the measured geometry and the `frame_start` strobe to gate capture.

## Interface
- `HW`, 12: width of horizontal counts, in clocks (one clock = 2 pixels)
- `VW`, 12: width of vertical counts, in lines
- `LOCK_FRAMES`, 2: consecutive matching frames required to assert lock (1..15)
- `TIMEOUT_W`, 22: frame watchdog width; timeout after 2^TIMEOUT_W clocks with no vsync rise

- `clk` input 1: pixel clock (receiver gclk domain)
- `rst_n` input 1: asynchronous active-low reset
- `v_valid` input 1: receiver valid; low acts as a synchronous clear
- `v_vsync` input 1: vsync, active high, already masked upstream
- `v_hsync` input 1: hsync, active high
- `v_de` input 1: data enable, active high
- `h_total` output HW: clocks per line
- `h_active` output HW: DE-high clocks per active line
- `v_total` output VW: lines per frame
- `v_active` output VW: active lines per frame
- `locked` output 1: geometry stable for LOCK_FRAMES frames
- `frame_start` output 1: one-cycle pulse per vsync rising edge
- `mode_change` output 1: one-cycle pulse when lock is lost

## Operation
- Edges: a rise is input=1 with the registered previous value=0. Falls are defined the same way, inverted. Previous-value registers clear on reset and when `v_valid`=0.
- Line period: `hcnt` is cleared on an hsync rise. Period = clocks between consecutive hsync rises; rises at cycles 0 and 10 give 10. It is latched into `line_total` at each rise.
- DE run: `decnt` counts DE-high clocks. On a DE fall, the run length is latched into `line_active` and `v_act_cnt` increments.
- Line consistency: within a frame, the first DE run sets `ref_active`. Any later run differing from it sets `frame_bad`.
- Frame: `v_tot_cnt` counts hsync rises in [vsync rise, next vsync rise). An hsync rise coincident with a vsync rise counts in the new frame.
- All counters saturate at all-ones. Saturation sets `frame_bad`.
- At a vsync rise, the frame just ended is "candidate" = {`line_total`, `line_active`, `v_tot_cnt`, `v_act_cnt`}.
  - The first vsync rise after reset or clear only arms measurement (`armed`=1). The partial frame is discarded and the outputs are unchanged.
  - Otherwise the outputs are loaded from the candidate.
  - The candidate matches if it equals the previous candidate, no field is zero, and `frame_bad`=0.
  - Match: `stable_cnt` increments, saturating at LOCK_FRAMES. `locked` is set when `stable_cnt` reaches LOCK_FRAMES.
  - Mismatch: `stable_cnt`=0 and `locked`=0. If `locked` was 1, `mode_change` pulses.
  - The candidate is stored as the previous candidate. Frame counters and `frame_bad` clear.
- Watchdog: `wdcnt` is cleared on a vsync rise. When it reaches all-ones:
  - `locked`=0 and `stable_cnt`=0.
  - Geometry outputs are zeroed and `armed`=0.
  - `mode_change` pulses if `locked` was 1.
  - `wdcnt` holds until the next vsync rise.
- `v_valid`=0: all state and outputs return to reset values, with no `mode_change` pulse.
- `frame_start` pulses on every qualified vsync rise, including the arming one, regardless of lock.

## Timing
- Reset values: all outputs 0, all counters 0, `armed`=0.
- All outputs are registered. For a vsync rise with the input high in cycle N:
  - `frame_start`, the geometry outputs, `locked` and `mode_change` update in cycle N+1.
  - `frame_start` and `mode_change` are high for exactly one cycle.
- A DE fall at cycle N makes `line_active` available at N+1. A DE fall coincident with a vsync rise belongs to the ending frame and is included in the candidate.
- A watchdog expiry coincident with a vsync rise: the vsync rise takes priority and the watchdog clears.
- Lock latency: with a steady source, `locked` rises at the (LOCK_FRAMES+1)th vsync rise after `v_valid` goes high.
- Asynchronous `rst_n` assertion mid-frame clears everything immediately. Deassertion is synchronised externally.

## Test plan
- Steady mode (h_total=10, h_active=6, v_total=8, v_active=5, LOCK_FRAMES=2): expect outputs 10/6/8/5 after 2nd vsync, `locked`=1 one cycle after 3rd vsync, `frame_start` on each vsync.
- Locked, then h_active changes to 4 in one frame: expect `mode_change` pulse and `locked`=0 at that frame's vsync+1; relock two frames later with h_active=4.
- One line in a frame with DE run 5 instead of 6: expect `frame_bad` mismatch, `stable_cnt` reset, `locked` drops.
- Locked, then vsync stopped (TIMEOUT_W=6): expect after 64 clocks `locked`=0, outputs 0, one `mode_change` pulse; vsync resumes and relocks after 3 vsyncs.
- `v_valid` deasserted for 1 cycle mid-frame while locked: expect all outputs 0 next cycle, no `mode_change`, first following vsync only arms.
- hsync stuck low for a frame (v_total=0 candidate): expect no lock, geometry v_total=0; a coincident hsync+vsync rise counts as line 1 of the new frame.
